// File: rtl/div_checker.sv
// Sequential divisibility checker: bit-serial restoring division, one step per clock,
// with valid/ready handshakes on the operand and result sides.
module div_checker #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_n,
   input  logic [WIDTH-1:0] in_d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_rem,
   output logic             out_div,
   output logic             out_dz
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] d_q, d_d;
   // Partial remainder stays below D, so its top bit is always zero and is not stored.
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div_q, div_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   t_c;
   logic [WIDTH:0]   d_ext_c;
   logic [WIDTH:0]   r_step_c;

   // One restoring-division step on WIDTH+1 bits.
   always_comb begin
      t_c      = {r_q, n_q[WIDTH-1]};
      d_ext_c  = {1'b0, d_q};
      r_step_c = (t_c >= d_ext_c) ? (t_c - d_ext_c) : t_c;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      d_d     = d_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               n_d   = in_n;
               d_d   = in_d;
               r_d   = '0;
               cnt_d = CW'(WIDTH);
               if (in_d == '0) begin
                  rem_d   = in_n;
                  div_d   = 1'b0;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            r_d   = r_step_c[WIDTH-1:0];
            n_d   = {n_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               rem_d   = r_step_c[WIDTH-1:0];
               div_d   = (r_step_c == '0);
               dz_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         div_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         d_q     <= d_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out_rem   = rem_q;
   assign out_div   = div_q;
   assign out_dz    = dz_q;

endmodule

// File: tb/tb_div_checker.sv
// Self-checking bench for div_checker: scoreboard of expected remainder/flags/latency.
module tb_div_checker;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_n;
   logic [W-1:0] in_d;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_rem;
   logic         out_div;
   logic         out_dz;

   typedef struct {
      logic [W-1:0] rem;
      logic         div;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks;
   int   failures;
   time  last_accept_t;

   div_checker #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_n      (in_n),
      .in_d      (in_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rem   (out_rem),
      .out_div   (out_div),
      .out_dz    (out_dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand pair at a negedge; returns at the negedge after the accept edge.
   task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d);
      exp_t e;
      bit   rdy;
      rdy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            rdy = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!rdy) begin
         failures++;
         $display("FAIL start_ready: in_ready=%0b required=1", in_ready);
      end
      e.dz  = (d == '0);
      e.rem = e.dz ? n : (n % d);
      e.div = !e.dz && (e.rem == '0);
      e.lat = e.dz ? 0 : int'(W);
      sb_q.push_back(e);
      in_n          = n;
      in_d          = d;
      in_valid      = 1'b1;
      last_accept_t = $time + 5;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, counting edges after the accept edge, and compare with the scoreboard.
   task automatic wait_result(input string tag);
      exp_t e;
      int   lat;
      bit   seen;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      e = sb_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: out_valid never rose within 50 cycles", tag);
         return;
      end
      checks++;
      if (out_rem !== e.rem || out_div !== e.div || out_dz !== e.dz) begin
         failures++;
         $display("FAIL %s_result: rem=%0d div=%0b dz=%0b required rem=%0d div=%0b dz=%0b",
                  tag, out_rem, out_div, out_dz, e.rem, e.div, e.dz);
      end
      checks++;
      if (lat != e.lat) begin
         failures++;
         $display("FAIL %s_latency: got=%0d required=%0d", tag, lat, e.lat);
      end
   endtask

   // With out_ready high, the handshake completes on the next edge.
   task automatic finish_hs(input string tag);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_handshake: out_valid=%0b in_ready=%0b required 0/1", tag, out_valid, in_ready);
      end
   endtask

   task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input string tag);
      start_op(n, d);
      wait_result(tag);
      finish_hs(tag);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_n      = '0;
      in_d      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rem !== '0 || out_div !== 1'b0 || out_dz !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: rdy=%0b vld=%0b rem=%0d div=%0b dz=%0b required 1/0/0/0/0",
                  in_ready, out_valid, out_rem, out_div, out_dz);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      do_op(8'd35, 8'd5, "n35_d5");
      do_op(8'd37, 8'd5, "n37_d5");
      do_op(8'd255, 8'd5, "n255_d5");
      do_op(8'd255, 8'd255, "n255_d255");
      do_op(8'd3, 8'd200, "n3_d200");
      do_op(8'd0, 8'd9, "n0_d9");
   endtask

   task automatic test_div_zero();
      do_op(8'd7, 8'd0, "n7_d0");
      do_op(8'd0, 8'd0, "n0_d0");
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      start_op(8'd37, 8'd5);
      wait_result("bp");
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_n     = 8'd1;
         in_d     = 8'd1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rem !== 8'd2 || out_div !== 1'b0 || out_dz !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: vld=%0b rdy=%0b rem=%0d div=%0b dz=%0b required 1/0/2/0/0",
                     out_valid, in_ready, out_rem, out_div, out_dz);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      finish_hs("bp");
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_ignored_input: vld=%0b rdy=%0b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      time t0;
      start_op(8'd200, 8'd3);
      t0 = last_accept_t;
      wait_result("b2b_a");
      finish_hs("b2b_a");
      start_op(8'd201, 8'd4);
      checks++;
      if (last_accept_t - t0 != time'(10 * (W + 2))) begin
         failures++;
         $display("FAIL b2b_period: got=%0t required=%0d", last_accept_t - t0, 10 * (W + 2));
      end
      wait_result("b2b_b");
      finish_hs("b2b_b");
   endtask

   task automatic test_reset_midop();
      do_op(8'd37, 8'd5, "pre_rst");
      start_op(8'd200, 8'd7);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb_q.pop_front());
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rem !== '0 || out_div !== 1'b0 || out_dz !== 1'b0) begin
         failures++;
         $display("FAIL midop_reset: rdy=%0b vld=%0b rem=%0d div=%0b dz=%0b required 1/0/0/0/0",
                  in_ready, out_valid, out_rem, out_div, out_dz);
      end
      repeat (12) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midop_no_result: out_valid=%0b required=0", out_valid);
      end
      rst_n = 1'b1;
      do_op(8'd100, 8'd7, "post_rst");
   endtask

   task automatic test_sweep();
      logic [W-1:0] dl [8];
      dl = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd10, 8'd128, 8'd255};
      foreach (dl[k]) begin
         for (int n = 0; n < 256; n++) begin
            do_op(W'(n), dl[k], "sweep");
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      @(negedge clk);
      test_basic();
      test_div_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
